// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode and FSM state types shared by the sequential ALU.
// Decimal adjust is only built when ALU_BCD_EN is defined.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_OR   = 4'h2,
    ALU_AND  = 4'h3,
    ALU_EOR  = 4'h4,
    ALU_INC  = 4'h5,
    ALU_DEC  = 4'h6,
    ALU_ASL  = 4'h7,
    ALU_ROL  = 4'h8,
    ALU_ROR  = 4'h9,
    ALU_LSR  = 4'hA,
    ALU_BIT  = 4'hB,
    ALU_PASS = 4'hC
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXEC    = 2'd1,
    ST_BCD_ADJ = 2'd2,
    ST_HOLD    = 2'd3
  } alu_state_t;

  function automatic logic is_arith(input alu_op_t op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/bcd_adjust.sv
// rtl/bcd_adjust.sv - decimal add/subtract, one 4-bit digit at a time.
// Used by alu_seq only when ALU_BCD_EN is defined.
module bcd_adjust #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic [WIDTH-1:0] y,
  output logic             c_out
);

  localparam int NIB = WIDTH / 4;

  logic       carry;
  logic       adj;
  logic [3:0] b_nib;
  logic [4:0] t;

  // carry means "decimal carry" for ADD and "no borrow" for SUB
  always_comb begin
    carry = c_in;
    adj   = 1'b0;
    b_nib = '0;
    t     = '0;
    y     = '0;
    for (int i = 0; i < NIB; i++) begin
      b_nib = sub ? ~b[4*i +: 4] : b[4*i +: 4];
      t     = {1'b0, a[4*i +: 4]} + {1'b0, b_nib} + {4'b0, carry};
      if (!sub) begin
        adj          = (t > 5'd9);
        y[4*i +: 4]  = adj ? (t[3:0] + 4'd6) : t[3:0];
        carry        = adj;
      end else begin
        y[4*i +: 4]  = t[4] ? t[3:0] : (t[3:0] - 4'd6);
        carry        = t[4];
      end
    end
    c_out = carry;
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU: accept, execute, optional decimal adjust, hold.
// Define ALU_BCD_EN to enable the BCD_ADJ state for decimal ADD/SUB.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_t          op,
  input  logic             c_in,
  input  logic             bcd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             c_out
);

  localparam int MSB = WIDTH - 1;

  alu_state_t       state_q;
  logic             in_ready_q, out_valid_q;
  logic [WIDTH-1:0] a_q, b_q, y_q;
  alu_op_t          op_q;
  logic             cin_q;
  logic             z_q, n_q, v_q, c_q;

  logic [WIDTH-1:0] y_d, b_eff;
  logic [WIDTH:0]   sum;
  logic             z_d, n_d, v_d, c_d;

  always_comb begin
    y_d   = '0;
    c_d   = 1'b0;
    v_d   = 1'b0;
    b_eff = (op_q == ALU_SUB) ? ~b_q : b_q;
    sum   = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin_q};
    case (op_q)
      ALU_ADD, ALU_SUB: begin
        y_d = sum[MSB:0];
        c_d = sum[WIDTH];
        v_d = (a_q[MSB] == b_eff[MSB]) && (sum[MSB] != a_q[MSB]);
      end
      ALU_OR:   y_d = a_q | b_q;
      ALU_AND:  y_d = a_q & b_q;
      ALU_EOR:  y_d = a_q ^ b_q;
      ALU_INC:  y_d = a_q + 1'b1;
      ALU_DEC:  y_d = a_q - 1'b1;
      ALU_ASL:  {c_d, y_d} = {a_q, 1'b0};
      ALU_ROL:  {c_d, y_d} = {a_q, cin_q};
      ALU_LSR:  {y_d, c_d} = {1'b0, a_q};
      ALU_ROR:  {y_d, c_d} = {cin_q, a_q};
      ALU_BIT: begin
        y_d = a_q & b_q;
        v_d = b_q[MSB-1];
      end
      ALU_PASS: y_d = b_q;
      default:  y_d = '0;
    endcase
    z_d = (y_d == '0);
    n_d = (op_q == ALU_BIT) ? b_q[MSB] : y_d[MSB];
  end

`ifdef ALU_BCD_EN
  logic             bcd_q;
  logic [WIDTH-1:0] dec_y;
  logic             dec_c;

  bcd_adjust #(.WIDTH(WIDTH)) u_bcd_adjust (
    .a     (a_q),
    .b     (b_q),
    .c_in  (cin_q),
    .sub   (op_q == ALU_SUB),
    .y     (dec_y),
    .c_out (dec_c)
  );
`else
  logic unused_bcd;
  assign unused_bcd = bcd;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      {z_q, n_q, v_q, c_q} <= 4'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            op_q       <= op;
            cin_q      <= c_in;
`ifdef ALU_BCD_EN
            bcd_q      <= bcd;
`endif
            in_ready_q <= 1'b0;
            state_q    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          y_q <= y_d;
          {z_q, n_q, v_q, c_q} <= {z_d, n_d, v_d, c_d};
`ifdef ALU_BCD_EN
          if (bcd_q && is_arith(op_q)) begin
            state_q <= ST_BCD_ADJ;
          end else begin
            state_q     <= ST_HOLD;
            out_valid_q <= 1'b1;
          end
`else
          state_q     <= ST_HOLD;
          out_valid_q <= 1'b1;
`endif
        end
`ifdef ALU_BCD_EN
        // overflow is left as computed on the binary pass
        ST_BCD_ADJ: begin
          y_q         <= dec_y;
          z_q         <= (dec_y == '0);
          n_q         <= dec_y[MSB];
          c_q         <= dec_c;
          state_q     <= ST_HOLD;
          out_valid_q <= 1'b1;
        end
`endif
        ST_HOLD: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign zero      = z_q;
  assign negative  = n_q;
  assign overflow  = v_q;
  assign c_out     = c_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed and random checks of alu_seq against an arithmetic model.
// Decimal expectations apply only when ALU_BCD_EN is defined.
module tb_alu_seq;
  import alu_pkg::*;

`ifdef ALU_BCD_EN
  localparam bit BCD_EN = 1'b1;
`else
  localparam bit BCD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, in_valid, in_ready, c_in, bcd, out_valid, out_ready;
  logic       zero, negative, overflow, c_out;
  logic [7:0] a, b, y;
  alu_op_t    op;
  int         checks = 0;
  int         failures = 0;

  typedef struct packed {
    logic [7:0] y;
    logic       z, n, v, c;
  } res_t;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .c_in(c_in), .bcd(bcd),
    .out_valid(out_valid), .out_ready(out_ready), .y(y),
    .zero(zero), .negative(negative), .overflow(overflow), .c_out(c_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sx(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  function automatic int ovf(input int x);
    return (x > 127 || x < -128) ? 1 : 0;
  endfunction

  function automatic void dec_model(input int o, input int ia, input int ib, input int cin,
                                    output int yy, output int c);
    int an, bn, t;
    c  = cin;
    yy = 0;
    for (int k = 0; k < 2; k++) begin
      an = (ia >> (4 * k)) % 16;
      bn = (ib >> (4 * k)) % 16;
      if (o == 0) begin
        t = an + bn + c;
        if (t > 9) begin t = t + 6; c = 1; end else c = 0;
      end else begin
        t = an - bn - (1 - c);
        if (t < 0) begin t = (t + 26) % 16; c = 0; end else c = 1;
      end
      yy = yy + ((t % 16) << (4 * k));
    end
  endfunction

  function automatic res_t model(input int o, input int ia, input int ib, input int cin, input int ibcd);
    res_t r;
    int   s, yy, c, v, nf;
    yy = 0; c = 0; v = 0; nf = -1;
    case (o)
      0:  begin s = ia + ib + cin; yy = s % 256; c = s / 256; v = ovf(sx(ia) + sx(ib) + cin); end
      1:  begin s = ia - ib - (1 - cin); c = (s >= 0) ? 1 : 0; yy = (s + 256) % 256;
                v = ovf(sx(ia) - sx(ib) - (1 - cin)); end
      2:  yy = ia | ib;
      3:  yy = ia & ib;
      4:  yy = ia ^ ib;
      5:  yy = (ia + 1) % 256;
      6:  yy = (ia + 255) % 256;
      7:  begin yy = (ia * 2) % 256; c = ia / 128; end
      8:  begin yy = (ia * 2 + cin) % 256; c = ia / 128; end
      9:  begin yy = ia / 2 + cin * 128; c = ia % 2; end
      10: begin yy = ia / 2; c = ia % 2; end
      11: begin yy = ia & ib; nf = ib / 128; v = (ib / 64) % 2; end
      12: yy = ib;
      default: yy = 0;
    endcase
    if (BCD_EN && ibcd != 0 && o <= 1) dec_model(o, ia, ib, cin, yy, c);
    r.y = yy[7:0];
    r.z = (yy == 0);
    r.n = (nf >= 0) ? nf[0] : (yy >= 128);
    r.v = v[0];
    r.c = c[0];
    return r;
  endfunction

  task automatic run_op(input int o, input int ia, input int ib, input int cin, input int ibcd,
                        input string tag);
    res_t e;
    int   lat, exp_lat, g;
    e       = model(o, ia, ib, cin, ibcd);
    exp_lat = (BCD_EN && ibcd != 0 && o <= 1) ? 3 : 2;
    g = 0;
    while (!in_ready && g < 10) begin @(negedge clk); g++; end
    check({tag, ":ready"}, in_ready, 1);
    a = ia[7:0]; b = ib[7:0]; op = alu_op_t'(o[3:0]); c_in = cin[0]; bcd = ibcd[0];
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin @(negedge clk); lat++; end
    check({tag, ":latency"}, lat, exp_lat);
    check({tag, ":y"}, y, e.y);
    check({tag, ":flags"}, {zero, negative, overflow, c_out}, {e.z, e.n, e.v, e.c});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ":idle"}, {in_ready, out_valid}, 2'b10);
  endtask

  initial begin
    int acc, both, g;
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    a = 8'h00; b = 8'h00; op = ALU_ADD; c_in = 1'b0; bcd = 1'b0;
    repeat (2) @(negedge clk);
    check("reset:hs", {in_ready, out_valid}, 2'b10);
    check("reset:y", y, 8'h00);
    check("reset:flags", {zero, negative, overflow, c_out}, 4'b0000);
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);

    run_op(0, 8'h7F, 8'h01, 0, 0, "add7f");
    check("add7f:y_const", y, 8'h80);
    check("add7f:flags_const", {zero, negative, overflow, c_out}, 4'b0110);
    run_op(1, 8'h00, 8'h01, 1, 0, "sub0");
    check("sub0:y_const", y, 8'hFF);
    check("sub0:flags_const", {zero, negative, overflow, c_out}, 4'b0100);
    run_op(5, 8'hFF, 8'h00, 0, 0, "incff");
    check("incff:flags_const", {y, zero}, {8'h00, 1'b1});
    run_op(9, 8'h01, 8'h00, 1, 0, "ror");
    check("ror:const", {y, c_out, negative}, {8'h80, 1'b1, 1'b1});
    run_op(11, 8'h00, 8'hC0, 0, 0, "bit");
    check("bit:const", {zero, negative, overflow}, 3'b111);
    run_op(0, 8'h58, 8'h46, 1, 1, "bcd_add");
    run_op(1, 8'h12, 8'h21, 1, 1, "bcd_sub");
`ifdef ALU_BCD_EN
    check("bcd_sub:const", {y, c_out}, {8'h91, 1'b0});
`else
    check("bin_sub:const", {y, c_out}, {8'hF1, 1'b0});
`endif

    for (int i = 0; i < 40; i++) begin
      run_op($urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255),
             $urandom_range(0, 1), $urandom_range(0, 1), "rand");
    end

    // stall in HOLD while a new request is presented
    a = 8'h10; b = 8'h20; op = ALU_ADD; c_in = 1'b0; bcd = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    g = 0;
    while (!out_valid && g < 10) begin @(negedge clk); g++; end
    a = 8'h55; b = 8'hAA; op = ALU_PASS; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold:y", {y, zero, negative, overflow, c_out}, {8'h30, 4'b0000});
      check("hold:hs", {in_ready, out_valid}, 2'b01);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    check("hold:release", {in_ready, out_valid, y}, {2'b10, 8'h30});

    // reset while executing, with competing handshakes
    a = 8'hFF; b = 8'h01; op = ALU_ADD; in_valid = 1'b1;
    @(negedge clk);
    reset = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("rst_exec:hs", {in_ready, out_valid}, 2'b10);
    check("rst_exec:y", {y, zero, negative, overflow, c_out}, {8'h00, 4'b0000});
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("rst_exec:idle", {in_ready, out_valid}, 2'b10);

    // back-to-back throughput
    a = 8'h01; b = 8'h5A; op = ALU_PASS; in_valid = 1'b1; out_ready = 1'b1;
    acc = 0; both = 0;
    for (int i = 0; i < 9; i++) begin
      if (in_ready) acc++;
      if (in_ready && out_valid) both++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b:accepts", acc, 3);
    check("b2b:exclusive", both, 0);
    check("b2b:y", y, 8'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, datapath width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operation request present.
REQ-005 in_ready  output  1  block accepts a request this cycle.
REQ-006 a, b  input  WIDTH  operands.
REQ-007 op  input  4  operation code, alu_op_t from alu_pkg.
REQ-008 c_in  input  1  carry in; for SUB/SBC, 1 means no borrow.
REQ-009 bcd  input  1  decimal mode request for ADD/SUB.
REQ-010 out_valid  output  1  result registers hold a valid result.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 y  output  WIDTH  registered result.
REQ-013 zero, negative, overflow, c_out  output  1 each  registered flags.

Function
REQ-014 States: IDLE, EXEC, BCD_ADJ, HOLD; in_ready SHALL be 1 only in IDLE.
REQ-015 Accept when in_valid && in_ready: capture a, b, op, c_in, bcd; go to EXEC.
REQ-016 EXEC computes binary result into y/flags; next state BCD_ADJ if captured bcd=1 and op is ADD or SUB (and ALU_BCD_EN defined), else HOLD.
REQ-017 Latency accept-to-out_valid: 2 cycles binary, 3 cycles decimal.
REQ-018 HOLD: out_valid=1; y and flags stable until out_ready=1, then IDLE next cycle.
REQ-019 out_valid and in_ready never both 1; back-to-back throughput one op per 3 cycles (binary).
REQ-020 ADD: {c_out,y}=a+b+c_in; SUB: {c_out,y}=a+~b+c_in.
REQ-021 overflow for ADD/SUB: operand MSBs (b inverted for SUB) equal and y MSB differs; all other ops: overflow=0, except BIT.
REQ-022 OR, AND, EOR: bitwise; c_out=0.
REQ-023 INC: a+1; DEC: a-1; c_out=0, wrap-around modulo 2^WIDTH.
REQ-024 ASL: {c_out,y}={a,0}; ROL: {c_out,y}={a,c_in}; LSR: {y,c_out}={0,a}; ROR: {y,c_out}={c_in,a}.
REQ-025 BIT: y=a&b; negative=b[WIDTH-1]; overflow=b[WIDTH-2]; c_out=0.
REQ-026 PASS: y=b; c_out=0. Unused op codes: y=0, c_out=0.
REQ-027 zero=(y==0); negative=y[WIDTH-1] except BIT; flags always reflect final y.
REQ-028 BCD_ADJ, per 4-bit nibble from LSB with carry ripple: ADD adds 6 when nibble>9 or nibble carry; SUB subtracts 6 when nibble borrowed; c_out = decimal carry (ADD) / no-borrow (SUB); overflow kept from EXEC.
REQ-029 Operand nibbles >9 in decimal mode: result defined only by REQ-028 arithmetic, no error flagged.

Reset
REQ-030 reset SHALL force IDLE, in_ready=1, out_valid=0, y=0, all flags 0 on the next edge, from any state, discarding any in-flight or held result.
REQ-031 reset takes priority over in_valid and out_ready in the same cycle.

Configuration
REQ-032 Macro ALU_BCD_EN: defined -> BCD_ADJ state and REQ-028 present; undefined -> bcd input ignored, BCD_ADJ never entered, all ops binary with REQ-017 binary latency.

Structure
REQ-033 alu_pkg holds alu_op_t (ADD=0, SUB=1, OR=2, AND=3, EOR=4, INC=5, DEC=6, ASL=7, ROL=8, ROR=9, LSR=A, BIT=B, PASS=C) and the state enum.
REQ-034 One sub-module, bcd_adjust: combinational, parameterised by WIDTH, performs REQ-028 correction; instantiated only under ALU_BCD_EN.

Verification (WIDTH=8)
REQ-035 ADD a=0x7F b=0x01 c_in=0 -> 2 cycles later y=0x80, overflow=1, negative=1, c_out=0, zero=0.
REQ-036 SUB a=0x00 b=0x01 c_in=1 -> y=0xFF, c_out=0, negative=1; INC a=0xFF -> y=0x00, zero=1.
REQ-037 ALU_BCD_EN, bcd=1 ADD a=0x58 b=0x46 c_in=1 -> 3 cycles later y=0x05, c_out=1; SUB a=0x12 b=0x21 c_in=1 -> y=0x91, c_out=0.
REQ-038 ROR a=0x01 c_in=1 -> y=0x80, c_out=1; BIT a=0x00 b=0xC0 -> zero=1, negative=1, overflow=1.
REQ-039 out_ready held 0 for 5 cycles in HOLD -> y/flags stable, in_ready=0, new in_valid ignored; reset asserted in EXEC -> next cycle out_valid=0, y=0, in_ready=1.
